// File: rtl/vga_background_fetcher.sv
// Fetches the next scanline's 3-word background descriptor during horizontal
// blanking and commits it to the renderer inputs if it lands before active video.
`timescale 1ns/1ps
module vga_background_fetcher #(
    parameter int ADDR_WIDTH = 16,
    parameter int ROWS       = 480
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  h_active,
    input  logic                  v_active,
    input  logic                  bg_enable,
    input  logic [ADDR_WIDTH-1:0] bg_base,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [31:0]           mem_data,
    output logic [31:0]           bg_pixels_0,
    output logic [31:0]           bg_pixels_1,
    output logic [5:0]            bg_size_0,
    output logic [5:0]            bg_size_1,
    output logic                  underrun
);

    localparam int ROW_W = $clog2(ROWS + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ0 = 2'd1;
    localparam logic [1:0] S_REQ1 = 2'd2;
    localparam logic [1:0] S_REQ2 = 2'd3;

    logic [1:0]            state;
    logic                  h_active_d;
    logic [ROW_W-1:0]      row;
    logic [ROW_W-1:0]      next_row;
    logic [ADDR_WIDTH-1:0] row_ext;
    logic [ADDR_WIDTH-1:0] fetch_base;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [31:0]           shadow_pixels_0;
    logic [31:0]           shadow_pixels_1;
    logic                  h_fall;
    logic                  h_rise;
    logic                  trigger;
    logic                  ack;

    assign h_fall  = h_active_d & ~h_active;
    assign h_rise  = ~h_active_d & h_active;
    assign trigger = h_fall && (state == S_IDLE) && bg_enable;
    assign ack     = mem_req & mem_ack;

    // Blanking lines and the last active line all prefetch row 0.
    always_comb begin
        next_row = '0;
        if (v_active && (row != ROW_W'(ROWS - 1)))
            next_row = row + 1'b1;
    end

    assign row_ext    = ADDR_WIDTH'(next_row);
    assign fetch_base = bg_base + row_ext + (row_ext << 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            h_active_d  <= 1'b0;
            row         <= '0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            underrun    <= 1'b0;
            bg_pixels_0 <= '0;
            bg_pixels_1 <= '0;
            bg_size_0   <= '0;
            bg_size_1   <= '0;
        end else begin
            h_active_d <= h_active;
            underrun   <= h_rise && (state != S_IDLE);

            if (!v_active)
                row <= '0;
            else if (h_fall)
                row <= row + 1'b1;

            case (state)
                S_IDLE: begin
                    if (trigger) begin
                        state    <= S_REQ0;
                        mem_req  <= 1'b1;
                        mem_addr <= fetch_base;
                    end
                end
                S_REQ0: begin
                    if (ack) begin
                        state    <= S_REQ1;
                        mem_addr <= base_addr + 1'b1;
                    end
                end
                S_REQ1: begin
                    if (ack) begin
                        state    <= S_REQ2;
                        mem_addr <= base_addr + 2'd2;
                    end
                end
                S_REQ2: begin
                    if (ack) begin
                        state   <= S_IDLE;
                        mem_req <= 1'b0;
                        // A descriptor that lands after active video began is dropped.
                        if (!h_active) begin
                            bg_pixels_0 <= shadow_pixels_0;
                            bg_pixels_1 <= shadow_pixels_1;
                            bg_size_0   <= mem_data[5:0];
                            bg_size_1   <= mem_data[13:8];
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Shadow capture holds data only, so it carries no reset.
    always_ff @(posedge clk) begin
        if (trigger)
            base_addr <= fetch_base;
        if (ack && (state == S_REQ0))
            shadow_pixels_0 <= mem_data;
        if (ack && (state == S_REQ1))
            shadow_pixels_1 <= mem_data;
    end

endmodule

// File: tb/tb_vga_background_fetcher.sv
// Scoreboard bench for vga_background_fetcher: expected reads and commits are
// queued at each line's falling h_active edge and checked by a monitor.
`timescale 1ns/1ps
module tb_vga_background_fetcher;

    localparam int ADDR_WIDTH = 16;
    localparam int ROWS       = 480;

    typedef struct packed {
        logic [31:0] p0;
        logic [31:0] p1;
        logic [5:0]  s0;
        logic [5:0]  s1;
    } commit_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        h_active = 1'b0;
    logic        v_active = 1'b0;
    logic        bg_enable = 1'b1;
    logic [15:0] bg_base = 16'h0100;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_data;
    logic [31:0] bg_pixels_0;
    logic [31:0] bg_pixels_1;
    logic [5:0]  bg_size_0;
    logic [5:0]  bg_size_1;
    logic        underrun;

    int          checks = 0;
    int          passes = 0;
    int          ucount = 0;
    int          ack_delay = 0;
    int          ack_cnt = 0;
    bit          force_ack = 1'b0;
    bit          special_on = 1'b0;
    logic [15:0] gen = 16'd0;
    logic [15:0] last_ack_addr = 16'd0;
    int          m_row = 0;
    commit_t     last_exp = '0;
    commit_t     prev;
    commit_t     cur;

    logic [15:0] addr_q[$];
    commit_t     commit_q[$];

    vga_background_fetcher #(.ADDR_WIDTH(ADDR_WIDTH), .ROWS(ROWS)) dut (
        .clk(clk), .reset(reset), .h_active(h_active), .v_active(v_active),
        .bg_enable(bg_enable), .bg_base(bg_base), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
        .bg_pixels_0(bg_pixels_0), .bg_pixels_1(bg_pixels_1),
        .bg_size_0(bg_size_0), .bg_size_1(bg_size_1), .underrun(underrun)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [15:0] a, input logic [15:0] g,
                                           input bit sp);
        if (sp && a == 16'h010F) return 32'hAAAA5555;
        if (sp && a == 16'h0110) return 32'h0F0F0F0F;
        if (sp && a == 16'h0111) return 32'h00000307;
        return {a, g};
    endfunction

    always_comb mem_data = mem_fn(mem_addr, gen, special_on);

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic note_fail(input string name, input logic [127:0] act);
        checks++;
        $display("FAIL %s: got %0h with nothing expected", name, act);
    endtask

    // Memory responder: ack after ack_delay idle cycles per word.
    always @(posedge clk) begin
        #2;
        if (mem_req === 1'b1) begin
            if (ack_cnt >= ack_delay) begin
                mem_ack = 1'b1;
                ack_cnt = 0;
            end else begin
                mem_ack = 1'b0;
                ack_cnt++;
            end
        end else begin
            mem_ack = force_ack;
            ack_cnt = 0;
        end
    end

    // Monitor: accepted reads and output commits are popped from the scoreboard.
    always @(negedge clk) begin
        if (underrun === 1'b1) ucount++;
        if (mem_req === 1'b1 && mem_ack === 1'b1) begin
            last_ack_addr = mem_addr;
            if (addr_q.size() == 0) note_fail("unexpected_read", mem_addr);
            else chk("read_addr", mem_addr, addr_q.pop_front());
        end
        cur = '{p0: bg_pixels_0, p1: bg_pixels_1, s0: bg_size_0, s1: bg_size_1};
        if (reset) prev = cur;
        else if (cur !== prev) begin
            if (commit_q.size() == 0) note_fail("unexpected_commit", cur);
            else chk("commit", cur, commit_q.pop_front());
            prev = cur;
        end
    end

    function automatic logic [15:0] model_fall(input bit v);
        int tgt;
        tgt = (v && m_row != ROWS - 1) ? m_row + 1 : 0;
        if (v) m_row++;
        return 16'(bg_base + 16'(3 * tgt));
    endfunction

    task automatic run_line(input bit v, input int a_len, input int b_len, input int delay,
                            input bit exp_fetch, input bit exp_commit);
        logic [15:0] base;
        commit_t     c;
        @(posedge clk); #1;
        v_active = v;
        h_active = 1'b1;
        if (!v) m_row = 0;
        repeat (a_len) @(posedge clk);
        #1;
        h_active = 1'b0;
        ack_delay = delay;
        gen++;
        base = model_fall(v);
        if (exp_fetch) begin
            addr_q.push_back(base);
            addr_q.push_back(16'(base + 16'd1));
            addr_q.push_back(16'(base + 16'd2));
        end
        if (exp_commit) begin
            c.p0 = mem_fn(base, gen, special_on);
            c.p1 = mem_fn(16'(base + 16'd1), gen, special_on);
            c.s0 = mem_fn(16'(base + 16'd2), gen, special_on)[5:0];
            c.s1 = mem_fn(16'(base + 16'd2), gen, special_on)[13:8];
            commit_q.push_back(c);
            last_exp = c;
        end
        repeat (b_len - 1) @(posedge clk);
        #1;
        chk("outputs_at_line_end",
            {bg_pixels_0, bg_pixels_1, bg_size_0, bg_size_1}, last_exp);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rbase;
        int          u_before;
        bit          found;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_mem_req", mem_req, 1'b0);
        chk("reset_mem_addr", mem_addr, 16'h0000);
        chk("reset_underrun", underrun, 1'b0);
        chk("reset_pixels_0", bg_pixels_0, 32'h0);
        chk("reset_pixels_1", bg_pixels_1, 32'h0);
        chk("reset_sizes", {bg_size_0, bg_size_1}, 12'h000);
        reset = 1'b0;

        for (int i = 0; i < 3; i++) run_line(1'b0, 4, 8, 0, 1'b1, 1'b1);
        chk("blank_last_read", last_ack_addr, 16'h0102);
        chk("blank_no_underrun", ucount, 0);

        for (int r = 0; r < ROWS; r++) begin
            special_on = (r == 4);
            run_line(1'b1, 4, 8, 0, 1'b1, 1'b1);
            if (r == 4) begin
                chk("row5_last_read", last_ack_addr, 16'h0111);
                chk("row5_pixels_0", bg_pixels_0, 32'hAAAA5555);
                chk("row5_pixels_1", bg_pixels_1, 32'h0F0F0F0F);
                chk("row5_size_0", bg_size_0, 6'd7);
                chk("row5_size_1", bg_size_1, 6'd3);
            end
            if (r == ROWS - 1) chk("last_row_prefetch_row0", last_ack_addr, 16'h0102);
        end
        special_on = 1'b0;
        chk("frame_no_underrun", ucount, 0);

        run_line(1'b0, 4, 8, 0, 1'b1, 1'b1);
        run_line(1'b0, 4, 8, 0, 1'b1, 1'b1);

        bg_base = 16'hFFFE;
        run_line(1'b1, 4, 8, 0, 1'b1, 1'b1);
        chk("wrap_last_read", last_ack_addr, 16'h0003);
        bg_base = 16'h0100;

        u_before = ucount;
        run_line(1'b1, 4, 12, 4, 1'b1, 1'b0);
        run_line(1'b1, 20, 8, 0, 1'b1, 1'b1);
        chk("underrun_pulses", ucount - u_before, 1);

        bg_enable = 1'b0;
        run_line(1'b1, 4, 8, 0, 1'b0, 1'b0);
        bg_enable = 1'b1;

        @(posedge clk); #1;
        h_active = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        h_active = 1'b0;
        ack_delay = 3;
        gen++;
        rbase = model_fall(1'b1);
        addr_q.push_back(rbase);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk); #1;
            if (mem_req === 1'b1 && mem_addr === 16'(rbase + 16'd1)) found = 1'b1;
        end
        if (!found) note_fail("reach_req1_timeout", mem_addr);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midreset_mem_req", mem_req, 1'b0);
        chk("midreset_outputs", {bg_pixels_0, bg_pixels_1, bg_size_0, bg_size_1}, 76'h0);
        chk("midreset_underrun", underrun, 1'b0);
        force_ack = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("stray_ack_mem_req", mem_req, 1'b0);
        chk("stray_ack_mem_addr", mem_addr, 16'h0000);
        chk("stray_ack_outputs", {bg_pixels_0, bg_pixels_1, bg_size_0, bg_size_1}, 76'h0);
        force_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        chk("reads_outstanding", addr_q.size(), 0);
        chk("commits_outstanding", commit_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
